// File: rtl/mem_array_sequencer.sv
// Row-major LOAD/DRAIN sequencer for a ROWS x COLS word array.
// The array is exposed live on arr and is streamed in or out via valid/ready.
module mem_array_sequencer #(
  parameter int W    = 16,
  parameter int ROWS = 4,
  parameter int COLS = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] arr [ROWS-1:0][COLS-1:0]
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q;
  logic [RW-1:0] row_q;
  logic [RW-1:0] row_d;
  logic [CW-1:0] col_q;
  logic [CW-1:0] col_d;
  logic          done_q;
  logic [W-1:0]  arr_q [ROWS-1:0][COLS-1:0];
  logic          at_last_s;

  // Row-major successor of the current (row, col) index
  always_comb begin
    at_last_s = (row_q == ROW_LAST) && (col_q == COL_LAST);
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = row_q + RW'(1);
    end else begin
      col_d = col_q + CW'(1);
      row_d = row_q;
    end
  end

  // Sequencer state, index counters, array storage and done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          arr_q[r][c] <= '0;
        end
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q <= cmd_op ? DRAIN : LOAD;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            arr_q[row_q][col_q] <= in_data;
            if (at_last_s) begin
              state_q <= IDLE;
              row_q   <= '0;
              col_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              row_q <= row_d;
              col_q <= col_d;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (at_last_s) begin
              state_q <= IDLE;
              row_q   <= '0;
              col_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              row_q <= row_d;
              col_q <= col_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          row_q   <= '0;
          col_q   <= '0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_data  = arr_q[row_q][col_q];
  assign out_last  = (state_q == DRAIN) && at_last_s;
  assign arr       = arr_q;

endmodule
